dec_control: RTL and testbench

Cycle-count sequencer for the decoder half of the network. It releases four decoder stages (dec1..dec4) one after another with active-low hold signals, using fixed per-stage latencies. Each stage budget includes that stage's activation: softplus for dec1..dec3, sigmoid for dec4. It sits downstream of the encoder controller: a `start` pulse, normally derived from the encoder's done flag, launches a run, and `done_flag` reports decoder completion to the top level.

---
 rtl/dec_control.sv | 188 ++++++++++++++++++
 tb/tb_dec_control.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dec_control.sv
// dec_control: cycle-count sequencer for the four decoder stages.
//
// A run is launched by `start` and releases dec1..dec4 in turn. Each release
// drives an active-low hold (decN_start) to 0 at a fixed cycle offset from the
// accepting edge. Each stage budget covers both its MAC and its activation.
// After the last stage's budget has elapsed, done_flag is raised and the
// counter stops.
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   start        run request (accepted in IDLE and DONE, ignored in RUN)
//   abort        run cancel (RUN/DONE -> IDLE), has priority over start
//   dec1_start   active-low hold for dec1 (1 = held, 0 = released)
//   dec2_start   active-low hold for dec2
//   dec3_start   active-low hold for dec3
//   dec4_start   active-low hold for dec4
//   busy         high while a run is in progress
//   done_flag    high from run completion until the next accepted start/abort
//   stage        index of the most recently released stage (0 = none)
//
// State table
//   state | meaning
//   IDLE  | no run, all stages held, counter cleared
//   RUN   | counting, stages released as their thresholds are reached
//   DONE  | all stages released, done_flag high, counter frozen at TD

module dec_control #(
  parameter int OFFSET  = 2,
  parameter int DEC1_CC = 8,
  parameter int ACT1    = 3,
  parameter int DEC2_CC = 8,
  parameter int ACT2    = 3,
  parameter int DEC3_CC = 12,
  parameter int ACT3    = 3,
  parameter int DEC4_CC = 12,
  parameter int ACT4    = 3,
  parameter int CC_W    = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  output logic       dec1_start,
  output logic       dec2_start,
  output logic       dec3_start,
  output logic       dec4_start,
  output logic       busy,
  output logic       done_flag,
  output logic [2:0] stage
);

  localparam int T1 = OFFSET;
  localparam int T2 = T1 + DEC1_CC + ACT1;
  localparam int T3 = T2 + DEC2_CC + ACT2;
  localparam int T4 = T3 + DEC3_CC + ACT3;
  localparam int TD = T4 + DEC4_CC + ACT4;

  localparam logic [CC_W-1:0] T1_C = CC_W'(T1);
  localparam logic [CC_W-1:0] T2_C = CC_W'(T2);
  localparam logic [CC_W-1:0] T3_C = CC_W'(T3);
  localparam logic [CC_W-1:0] T4_C = CC_W'(T4);
  localparam logic [CC_W-1:0] TD_C = CC_W'(TD);

  // Thresholds must be strictly increasing and the terminal count must fit
  // in the counter, otherwise a release could be skipped or the count wrap.
  if (OFFSET < 1) begin : g_bad_offset
    $error("dec_control: OFFSET must be at least 1");
  end
  if ((DEC1_CC + ACT1 < 1) || (DEC2_CC + ACT2 < 1) ||
      (DEC3_CC + ACT3 < 1) || (DEC4_CC + ACT4 < 1)) begin : g_bad_budget
    $error("dec_control: every DECn_CC + ACTn must be at least 1");
  end
  if (longint'(TD) >= (longint'(1) << CC_W)) begin : g_bad_width
    $error("dec_control: TD does not fit in CC_W bits");
  end

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      state;
  logic [CC_W-1:0] cc;
  logic [CC_W-1:0] cc_next;

  assign cc_next = cc + CC_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cc         <= '0;
      dec1_start <= 1'b1;
      dec2_start <= 1'b1;
      dec3_start <= 1'b1;
      dec4_start <= 1'b1;
      busy       <= 1'b0;
      done_flag  <= 1'b0;
      stage      <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_RUN;
            cc    <= '0;
            busy  <= 1'b1;
          end
        end

        S_RUN: begin
          if (abort) begin
            state      <= S_IDLE;
            cc         <= '0;
            dec1_start <= 1'b1;
            dec2_start <= 1'b1;
            dec3_start <= 1'b1;
            dec4_start <= 1'b1;
            busy       <= 1'b0;
            done_flag  <= 1'b0;
            stage      <= 3'd0;
          end else begin
            cc <= cc_next;
            // Compare against the value cc takes on this edge so the hold
            // drops exactly Tn edges after the accepting edge.
            if (cc_next == T1_C) begin
              dec1_start <= 1'b0;
              stage      <= 3'd1;
            end
            if (cc_next == T2_C) begin
              dec2_start <= 1'b0;
              stage      <= 3'd2;
            end
            if (cc_next == T3_C) begin
              dec3_start <= 1'b0;
              stage      <= 3'd3;
            end
            if (cc_next == T4_C) begin
              dec4_start <= 1'b0;
              stage      <= 3'd4;
            end
            if (cc_next == TD_C) begin
              state     <= S_DONE;
              busy      <= 1'b0;
              done_flag <= 1'b1;
            end
          end
        end

        S_DONE: begin
          if (abort) begin
            state      <= S_IDLE;
            cc         <= '0;
            dec1_start <= 1'b1;
            dec2_start <= 1'b1;
            dec3_start <= 1'b1;
            dec4_start <= 1'b1;
            busy       <= 1'b0;
            done_flag  <= 1'b0;
            stage      <= 3'd0;
          end else if (start) begin
            // Re-arm directly into a new run.
            state      <= S_RUN;
            cc         <= '0;
            dec1_start <= 1'b1;
            dec2_start <= 1'b1;
            dec3_start <= 1'b1;
            dec4_start <= 1'b1;
            busy       <= 1'b1;
            done_flag  <= 1'b0;
            stage      <= 3'd0;
          end
        end

        default: begin
          state      <= S_IDLE;
          cc         <= '0;
          dec1_start <= 1'b1;
          dec2_start <= 1'b1;
          dec3_start <= 1'b1;
          dec4_start <= 1'b1;
          busy       <= 1'b0;
          done_flag  <= 1'b0;
          stage      <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dec_control.sv
// tb_dec_control: self-checking bench for dec_control.
//
// Two instances share all inputs: one with default parameters and one with
// OFFSET = 1, DEC1_CC = 1, ACT1 = 0. A reference model tracks, per instance,
// whether a run exists and the edge that accepted it; expected outputs are
// derived from the elapsed edge count against the threshold list.

module tb_dec_control;

  logic clk;
  logic reset_n;
  logic start;
  logic abort;

  logic       d0_dec1, d0_dec2, d0_dec3, d0_dec4, d0_busy, d0_done;
  logic [2:0] d0_stage;
  logic       d1_dec1, d1_dec2, d1_dec3, d1_dec4, d1_busy, d1_done;
  logic [2:0] d1_stage;

  dec_control u_dut_def (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .dec1_start (d0_dec1),
    .dec2_start (d0_dec2),
    .dec3_start (d0_dec3),
    .dec4_start (d0_dec4),
    .busy       (d0_busy),
    .done_flag  (d0_done),
    .stage      (d0_stage)
  );

  dec_control #(
    .OFFSET  (1),
    .DEC1_CC (1),
    .ACT1    (0)
  ) u_dut_ovr (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .dec1_start (d1_dec1),
    .dec2_start (d1_dec2),
    .dec3_start (d1_dec3),
    .dec4_start (d1_dec4),
    .busy       (d1_busy),
    .done_flag  (d1_done),
    .stage      (d1_stage)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // thresholds per instance: T1, T2, T3, T4, TD
  int t [2][5];
  bit have_run [2];
  int e0 [2];
  int k;
  int n_chk;
  int n_pass;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s @edge %0d: got %b want %b (dec1..4,busy,done,stage)",
                  tag, k, obs, exp);
  endtask

  function automatic logic [8:0] model_out(input int d);
    int el;
    logic [3:0] holds;
    logic [2:0] stg;
    if (!have_run[d]) return 9'b1111_0_0_000;
    el = k - e0[d];
    holds = 4'b1111;
    stg   = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (el >= t[d][i]) begin
        holds[3-i] = 1'b0;
        stg = 3'(i + 1);
      end
    end
    return {holds, (el < t[d][4]), (el >= t[d][4]), stg};
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "_def"}, {d0_dec1, d0_dec2, d0_dec3, d0_dec4, d0_busy, d0_done, d0_stage},
        model_out(0));
    chk({tag, "_ovr"}, {d1_dec1, d1_dec2, d1_dec3, d1_dec4, d1_busy, d1_done, d1_stage},
        model_out(1));
  endtask

  task automatic model_edge(input logic s, input logic a);
    for (int d = 0; d < 2; d++) begin
      if (!reset_n) have_run[d] = 1'b0;
      else if (a && have_run[d]) have_run[d] = 1'b0;
      else if (s && (!have_run[d] || ((k - 1 - e0[d]) >= t[d][4]))) begin
        have_run[d] = 1'b1;
        e0[d] = k;
      end
    end
  endtask

  task automatic step(input logic s, input logic a);
    start = s;
    abort = a;
    @(posedge clk);
    k++;
    model_edge(s, a);
    @(negedge clk);
    check_all("cyc");
  endtask

  // Reset asserted mid-cycle: outputs must return to idle before any edge.
  task automatic async_reset_mid();
    start = 1'b0;
    abort = 1'b0;
    #2 reset_n = 1'b0;
    have_run[0] = 1'b0;
    have_run[1] = 1'b0;
    #1 check_all("async_rst");
    @(posedge clk);
    k++;
    @(negedge clk);
    check_all("rst_hold");
    reset_n = 1'b1;
  endtask

  function automatic void set_thr(input int d, input int off, input int c1, input int a1,
                                  input int c2, input int a2, input int c3, input int a3,
                                  input int c4, input int a4);
    t[d][0] = off;
    t[d][1] = t[d][0] + c1 + a1;
    t[d][2] = t[d][1] + c2 + a2;
    t[d][3] = t[d][2] + c3 + a3;
    t[d][4] = t[d][3] + c4 + a4;
  endfunction

  initial begin
    n_chk = 0;
    n_pass = 0;
    k = 0;
    have_run[0] = 1'b0;
    have_run[1] = 1'b0;
    e0[0] = 0;
    e0[1] = 0;
    set_thr(0, 2, 8, 3, 8, 3, 12, 3, 12, 3);
    set_thr(1, 1, 1, 0, 8, 3, 12, 3, 12, 3);

    reset_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check_all("reset");
    @(negedge clk);
    reset_n = 1'b1;

    repeat (3) step(1'b0, 1'b0);

    // single start pulse through completion
    step(1'b1, 1'b0);
    repeat (60) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);

    // start held for 10 cycles from IDLE
    repeat (10) step(1'b1, 1'b0);
    repeat (50) step(1'b0, 1'b0);

    // re-arm from DONE
    step(1'b1, 1'b0);
    repeat (60) step(1'b0, 1'b0);

    // abort at E0+20, then a fresh run
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    repeat (19) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (60) step(1'b0, 1'b0);

    // async reset around E0+30, then nominal run
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    repeat (29) step(1'b0, 1'b0);
    async_reset_mid();
    step(1'b1, 1'b0);
    repeat (60) step(1'b0, 1'b0);

    // randomized traffic
    repeat (2000) begin
      if ($urandom_range(0, 300) == 0) async_reset_mid();
      else step(($urandom_range(0, 15) == 0), ($urandom_range(0, 40) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
